// File: rtl/cache_pkg.sv
// cache_pkg: shared controller states and default geometry for the 2-way write-back cache
package cache_pkg;
    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;
    localparam int DEF_ADDR_W    = 30;
    localparam int DEF_WORD_W    = 32;
    localparam int DEF_BLK_WORDS = 4;
    localparam int DEF_SETS      = 4;
endpackage

// File: rtl/cache_2way_wb_if.sv
// cache_2way_wb_if: processor request/response and memory block bus seen by the cache
interface cache_2way_wb_if #(
    parameter int ADDR_W    = cache_pkg::DEF_ADDR_W,
    parameter int WORD_W    = cache_pkg::DEF_WORD_W,
    parameter int BLK_WORDS = cache_pkg::DEF_BLK_WORDS
);
    localparam int OFFSET_W = $clog2(BLK_WORDS);
    logic                        proc_read;
    logic                        proc_write;
    logic [ADDR_W-1:0]           proc_addr;
    logic [WORD_W-1:0]           proc_wdata;
    logic                        proc_stall;
    logic [WORD_W-1:0]           proc_rdata;
    logic                        mem_read;
    logic                        mem_write;
    logic [ADDR_W-OFFSET_W-1:0]  mem_addr;
    logic [WORD_W*BLK_WORDS-1:0] mem_wdata;
    logic [WORD_W*BLK_WORDS-1:0] mem_rdata;
    logic                        mem_ready;
    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_way_array.sv
// cache_way_array: one way of tag/valid/dirty/data storage, read by index, one fill-or-word write port
module cache_way_array
    import cache_pkg::*;
#(
    parameter int SETS      = DEF_SETS,
    parameter int TAG_W     = 26,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int BLK_WORDS = DEF_BLK_WORDS,
    localparam int INDEX_W  = $clog2(SETS),
    localparam int OFFSET_W = $clog2(BLK_WORDS),
    localparam int BLK_W    = WORD_W * BLK_WORDS
) (
    input  logic                clk,
    input  logic                proc_reset,
    input  logic [INDEX_W-1:0]  idx_i,
    input  logic [OFFSET_W-1:0] off_i,
    input  logic [TAG_W-1:0]    tag_i,
    input  logic                fill_i,
    input  logic                wr_i,
    input  logic [WORD_W-1:0]   wdata_i,
    input  logic [BLK_W-1:0]    fill_blk_i,
    output logic                valid_o,
    output logic                dirty_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic [BLK_W-1:0]    blk_o
);
    logic [SETS-1:0]  valid_q;
    logic [SETS-1:0]  dirty_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [BLK_W-1:0] data_q [SETS];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign blk_o   = data_q[idx_i];

    // fill has priority: a word write never coincides with a fill of the same way
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                tag_q[s]  <= '0;
                data_q[s] <= '0;
            end
        end else if (fill_i) begin
            data_q[idx_i]  <= fill_blk_i;
            tag_q[idx_i]   <= tag_i;
            valid_q[idx_i] <= 1'b1;
            dirty_q[idx_i] <= 1'b0;
        end else if (wr_i) begin
            data_q[idx_i][off_i*WORD_W +: WORD_W] <= wdata_i;
            dirty_q[idx_i] <= 1'b1;
        end
    end
endmodule

// File: rtl/cache_2way_wb.sv
// cache_2way_wb: 2-way set-associative write-back write-allocate L1 with per-set LRU
module cache_2way_wb
    import cache_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int BLK_WORDS = DEF_BLK_WORDS,
    parameter int SETS      = DEF_SETS,
    localparam int OFFSET_W = $clog2(BLK_WORDS),
    localparam int INDEX_W  = $clog2(SETS),
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
    localparam int BLK_W    = WORD_W * BLK_WORDS
) (
    input logic              clk,
    input logic              proc_reset,
    cache_2way_wb_if.slave   bus
);
    state_t               state_q;
    logic                 victim_q;
    logic [SETS-1:0]      lru_q;
    logic [OFFSET_W-1:0]  off;
    logic [INDEX_W-1:0]   idx;
    logic [TAG_W-1:0]     tag;
    logic [1:0]           way_valid, way_dirty, way_hit, way_fill, way_wr;
    logic [TAG_W-1:0]     way_tag [2];
    logic [BLK_W-1:0]     way_blk [2];
    logic                 idle, req, hit, miss, victim;
    logic [BLK_W-1:0]     hit_blk;

    assign off  = bus.proc_addr[OFFSET_W-1:0];
    assign idx  = bus.proc_addr[OFFSET_W +: INDEX_W];
    assign tag  = bus.proc_addr[ADDR_W-1 -: TAG_W];
    assign idle = state_q == IDLE;
    assign req  = idle & (bus.proc_read ^ bus.proc_write);

    for (genvar w = 0; w < 2; w++) begin : g_way
        assign way_hit[w]  = way_valid[w] & (way_tag[w] == tag);
        assign way_fill[w] = (state_q == ALLOCATE) & bus.mem_ready & (victim_q == 1'(w));
        assign way_wr[w]   = req & bus.proc_write & way_hit[w];
        cache_way_array #(
            .SETS(SETS), .TAG_W(TAG_W), .WORD_W(WORD_W), .BLK_WORDS(BLK_WORDS)
        ) u_way (
            .clk        (clk),
            .proc_reset (proc_reset),
            .idx_i      (idx),
            .off_i      (off),
            .tag_i      (tag),
            .fill_i     (way_fill[w]),
            .wr_i       (way_wr[w]),
            .wdata_i    (bus.proc_wdata),
            .fill_blk_i (bus.mem_rdata),
            .valid_o    (way_valid[w]),
            .dirty_o    (way_dirty[w]),
            .tag_o      (way_tag[w]),
            .blk_o      (way_blk[w])
        );
    end

    assign hit     = req & (|way_hit);
    assign miss    = req & ~(|way_hit);
    // an invalid way is always preferred over evicting a live line
    assign victim  = ~way_valid[0] ? 1'b0 : ~way_valid[1] ? 1'b1 : lru_q[idx];
    assign hit_blk = way_hit[1] ? way_blk[1] : way_blk[0];

    assign bus.proc_stall = ~idle | miss;
    assign bus.proc_rdata = (hit & bus.proc_read) ? hit_blk[off*WORD_W +: WORD_W] : '0;
    assign bus.mem_read   = state_q == ALLOCATE;
    assign bus.mem_write  = state_q == WRITEBACK;
    assign bus.mem_addr   = {(state_q == WRITEBACK) ? way_tag[victim_q] : tag, idx};
    assign bus.mem_wdata  = way_blk[victim_q];

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q  <= IDLE;
            victim_q <= 1'b0;
            lru_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) lru_q[idx] <= way_hit[0];
                    if (miss) begin
                        victim_q <= victim;
                        state_q  <= way_dirty[victim] ? WRITEBACK : ALLOCATE;
                    end
                end
                WRITEBACK: if (bus.mem_ready) state_q <= ALLOCATE;
                ALLOCATE:  if (bus.mem_ready) state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_2way_wb.sv
// tb_cache_2way_wb: directed checks of hits, fills, dirty eviction, stalls and reset for cache_2way_wb
module tb_cache_2way_wb;
    logic clk = 1'b0;
    logic proc_reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cache_2way_wb_if bus ();
    cache_2way_wb dut (.clk(clk), .proc_reset(proc_reset), .bus(bus));

    localparam logic [127:0] BLK_A = {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};
    localparam logic [127:0] BLK_E = {32'h00000044, 32'h00000033, 32'h00000022, 32'h00000011};
    localparam logic [127:0] BLK_I = {32'h00000099, 32'h00000088, 32'h00000077, 32'h00000066};
    localparam logic [127:0] WB    = {32'h0000000D, 32'h0000000C, 32'hDEADBEEF, 32'h12345678};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic r, input logic w, input logic [29:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.proc_read = r; bus.proc_write = w; bus.proc_addr = a; bus.proc_wdata = d;
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic mem_ack(input logic [127:0] d);
        bus.mem_rdata = d;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
    endtask

    initial begin
        bus.proc_read = 0; bus.proc_write = 0; bus.proc_addr = '0; bus.proc_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 0;
        #12 proc_reset = 1'b0;
        #1;
        chk("rst_stall", bus.proc_stall, 0);
        chk("rst_mem_read", bus.mem_read, 0);
        chk("rst_mem_write", bus.mem_write, 0);
        chk("rst_rdata", bus.proc_rdata, 0);

        req(1, 0, 30'h04, 0);
        chk("cold_stall", bus.proc_stall, 1);
        chk("cold_no_strobe_yet", bus.mem_read, 0);
        cyc();
        chk("cold_mem_read", bus.mem_read, 1);
        chk("cold_mem_addr", bus.mem_addr, 28'h01);
        chk("cold_stall_alloc", bus.proc_stall, 1);
        mem_ack(BLK_A);
        chk("cold_rehit_stall", bus.proc_stall, 0);
        chk("cold_rdata", bus.proc_rdata, 32'h0000000A);
        chk("cold_mem_idle", bus.mem_read, 0);
        req(1, 0, 30'h06, 0);
        chk("hit_word2", bus.proc_rdata, 32'h0000000C);

        req(0, 1, 30'h05, 32'hDEADBEEF);
        chk("wr_hit_stall", bus.proc_stall, 0);
        chk("wr_hit_no_mem", {bus.mem_read, bus.mem_write}, 0);
        req(1, 0, 30'h05, 0);
        chk("wr_hit_readback", bus.proc_rdata, 32'hDEADBEEF);

        req(1, 0, 30'h14, 0);
        chk("way1_miss_stall", bus.proc_stall, 1);
        cyc();
        chk("way1_mem_read", bus.mem_read, 1);
        chk("way1_mem_addr", bus.mem_addr, 28'h05);
        mem_ack(BLK_E);
        chk("way1_rdata", bus.proc_rdata, 32'h00000011);
        req(0, 1, 30'h04, 32'h12345678);
        chk("dirty_wr_stall", bus.proc_stall, 0);
        req(1, 0, 30'h14, 0);
        chk("way1_still_hit", bus.proc_rdata, 32'h00000011);
        req(1, 0, 30'h05, 0);
        chk("way0_still_hit", bus.proc_rdata, 32'hDEADBEEF);
        req(1, 0, 30'h14, 0);

        req(1, 0, 30'h24, 0);
        chk("evict_stall", bus.proc_stall, 1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("wb_mem_write", bus.mem_write, 1);
            chk("wb_mem_read", bus.mem_read, 0);
            chk("wb_mem_addr", bus.mem_addr, 28'h01);
            chk("wb_mem_wdata", bus.mem_wdata, WB);
            chk("wb_stall", bus.proc_stall, 1);
        end
        mem_ack('0);
        for (int i = 0; i < 5; i++) begin
            chk("alloc_mem_read", bus.mem_read, 1);
            chk("alloc_mem_write", bus.mem_write, 0);
            chk("alloc_mem_addr", bus.mem_addr, 28'h09);
            chk("alloc_stall", bus.proc_stall, 1);
            cyc();
        end
        mem_ack(BLK_I);
        chk("evict_rehit_stall", bus.proc_stall, 0);
        chk("evict_rdata", bus.proc_rdata, 32'h00000066);
        req(1, 0, 30'h14, 0);
        chk("other_way_kept", bus.proc_rdata, 32'h00000011);
        chk("other_way_stall", bus.proc_stall, 0);

        req(1, 1, 30'h24, 32'hBAD0BAD0);
        chk("rw_hit_stall", bus.proc_stall, 0);
        req(1, 1, 30'h04, 32'hBAD0BAD0);
        chk("rw_miss_stall", bus.proc_stall, 0);
        cyc();
        chk("rw_no_mem", {bus.mem_read, bus.mem_write}, 0);
        req(1, 0, 30'h24, 0);
        chk("rw_no_write", bus.proc_rdata, 32'h00000066);
        chk("rw_no_write_stall", bus.proc_stall, 0);
        req(1, 0, 30'h14, 0);
        chk("rw_no_lru_change", bus.proc_rdata, 32'h00000011);

        req(1, 0, 30'h44, 0);
        cyc();
        chk("rst_alloc_mem_read", bus.mem_read, 1);
        bus.proc_read = 0;
        proc_reset = 1'b1;
        #1;
        chk("rst_async_mem_read", bus.mem_read, 0);
        chk("rst_async_stall", bus.proc_stall, 0);
        @(negedge clk);
        proc_reset = 1'b0;
        req(1, 0, 30'h04, 0);
        chk("post_rst_miss", bus.proc_stall, 1);
        cyc();
        chk("post_rst_mem_read", bus.mem_read, 1);
        chk("post_rst_mem_addr", bus.mem_addr, 28'h01);
        mem_ack(BLK_A);
        chk("post_rst_rdata", bus.proc_rdata, 32'h0000000A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
